// File: rtl/ernic_cmac_tx_pkt_fifo_if.sv
// ---------------------------------------------------------------------------
// ernic_cmac_tx_pkt_fifo_if
//
// AXI4-Stream style bundle used on both sides of the ERNIC -> CMAC TX packet
// buffer.
//
// Signals:
//   tdata   DATA_WIDTH      beat payload
//   tkeep   DATA_WIDTH/8    byte enables
//   tvalid  1               beat valid
//   tlast   1               end of frame
//   tready  1               sink accepts the beat
//
// Modports:
//   master  drives tdata/tkeep/tvalid/tlast, samples tready
//   slave   samples tdata/tkeep/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface ernic_cmac_tx_pkt_fifo_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/ernic_cmac_tx_pkt_fifo.sv
// ---------------------------------------------------------------------------
// ernic_cmac_tx_pkt_fifo
//
// Store-and-forward TX packet buffer between the ERNIC transmit stream and
// the CMAC 512-bit TX AXIS user interface. A frame is only released toward
// CMAC once all of its beats are buffered, so the egress tvalid never drops
// in the middle of a frame. A frame that meets a full buffer is discarded
// whole and counted; already stored frames are untouched.
//
// Ports:
//   aclk          single clock (CMAC txusrclk2 domain)
//   aresetn       synchronous active-low reset
//   s_axis        ingress stream from ERNIC (slave); no backpressure, its
//                 tready is tied high
//   m_axis        egress stream to CMAC tx_axis_* (master)
//   m_axis_tuser  CMAC tx_axis_tuser, constant 0
//   pkt_count     complete frames stored and not yet fully sent
//   drop_count    dropped frames, saturating at 0xFFFF
//   drop_pulse    one-cycle pulse per dropped frame
// ---------------------------------------------------------------------------
module ernic_cmac_tx_pkt_fifo #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 64
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    ernic_cmac_tx_pkt_fifo_if.slave  s_axis,
    ernic_cmac_tx_pkt_fifo_if.master m_axis,
    output logic                     m_axis_tuser,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [15:0]              drop_count,
    output logic                     drop_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + KW + 1;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } ingress_state_t;

    ingress_state_t state, next_state;

    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_commit;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] used;
    logic          full;
    logic          have_data;

    logic          wr_en;
    logic          commit;
    logic          drop;

    logic          load;
    logic          handshake;
    logic          pkt_dec;
    logic [EW-1:0] rd_entry;

    logic                  out_valid;
    logic                  out_last;
    logic [KW-1:0]         out_keep;
    logic [DATA_WIDTH-1:0] out_data;

    // The ingress side has no backpressure: every beat is either stored or
    // discarded, so the stream is always ready.
    assign s_axis.tready = 1'b1;

    // Pointers carry one extra wrap bit so that full (distance DEPTH) and
    // empty (distance 0) are distinguishable. The egress side only sees data
    // up to the commit pointer, i.e. complete frames.
    assign used      = wr_ptr - rd_ptr;
    assign full      = (used == PW'(DEPTH));
    assign have_data = (rd_ptr != wr_commit);

    // Ingress FSM next-state and beat disposition. A beat hitting a full
    // buffer throws away the partial frame already written (wr_ptr rewinds
    // to the last commit) and, unless it is the tail, the rest of the frame
    // is swallowed in DROP.
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        commit     = 1'b0;
        drop       = 1'b0;
        unique case (state)
            ACCEPT: begin
                if (s_axis.tvalid) begin
                    if (!full) begin
                        wr_en  = 1'b1;
                        commit = s_axis.tlast;
                    end else begin
                        drop = 1'b1;
                        if (!s_axis.tlast) begin
                            next_state = DROP;
                        end
                    end
                end
            end
            DROP: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    next_state = ACCEPT;
                end
            end
            default: next_state = ACCEPT;
        endcase
    end

    // Ingress state, write pointers and drop statistics.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= ACCEPT;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            drop_count <= '0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= next_state;
            drop_pulse <= drop;
            if (drop) begin
                wr_ptr <= wr_commit;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (commit) begin
                wr_commit <= wr_ptr + PW'(1);
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Frame storage; contents need no reset because only committed entries
    // are ever read.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        end
    end

    assign rd_entry  = mem[rd_ptr[AW-1:0]];
    assign handshake = out_valid && m_axis.tready;
    assign load      = have_data && (!out_valid || m_axis.tready);
    assign pkt_dec   = handshake && out_last;

    // First-word fall-through output register: refilled whenever it is empty
    // or its beat is being taken, which gives one beat per cycle and no gap
    // between frames that are already committed.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_keep  <= '0;
            out_data  <= '0;
        end else if (load) begin
            rd_ptr    <= rd_ptr + PW'(1);
            out_valid <= 1'b1;
            out_last  <= rd_entry[EW-1];
            out_keep  <= rd_entry[DATA_WIDTH +: KW];
            out_data  <= rd_entry[DATA_WIDTH-1:0];
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Stored frame count: up on commit, down on the tail handshake; both in
    // the same cycle cancel out.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_count <= '0;
        end else begin
            unique case ({commit, pkt_dec})
                2'b10:   pkt_count <= pkt_count + PW'(1);
                2'b01:   pkt_count <= pkt_count - PW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tdata  = out_data;
    assign m_axis_tuser  = 1'b0;

endmodule
